// File: rtl/ram_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_access_unit                                               |
// | Desc     : Big-endian byte-addressed RAM with a multi-cycle access FSM    |
// |            reporting completion (MFC) and fault (MSET).                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ram_access_unit #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  RESET_n,
  input  logic                  RAM_enable,
  input  logic [5:0]            RAM_OpCode,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MFC,
  output logic                  MSET
);

  localparam int         c_DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [1:0] c_SZ_BYTE   = 2'd0;
  localparam logic [1:0] c_SZ_HALF   = 2'd1;
  localparam logic [1:0] c_SZ_WORD   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [5:0]            r_op;
  logic [31:0]           r_din;
  logic [7:0]            r_mem [0:c_DEPTH-1];

  logic                  w_accept, w_finish, w_from_idle;
  logic [ADDR_WIDTH-1:0] w_addr, w_a1, w_a2, w_a3;
  logic [5:0]            w_op;
  logic [31:0]           w_din;
  logic                  w_legal, w_is_load, w_signed, w_aligned, w_fault, w_do_store;
  logic [1:0]            w_size;
  logic [7:0]            w_b0, w_b1, w_b2, w_b3;
  logic [31:0]           w_load_val;

  assign w_accept    = (r_state == S_IDLE) && RAM_enable;
  assign w_finish    = ((r_state == S_WAIT) && (r_count == 4'd1)) ||
                       (w_accept && (WAIT_CYCLES == 0));
  // With zero wait cycles the access completes on the accepting edge, so the
  // live inputs stand in for the not-yet-latched copies.
  assign w_from_idle = (r_state == S_IDLE);
  assign w_addr      = w_from_idle ? Address    : r_addr;
  assign w_op        = w_from_idle ? RAM_OpCode : r_op;
  assign w_din       = w_from_idle ? DataIn     : r_din;

  assign w_a1 = w_addr + ADDR_WIDTH'(1);
  assign w_a2 = w_addr + ADDR_WIDTH'(2);
  assign w_a3 = w_addr + ADDR_WIDTH'(3);
  assign w_b0 = r_mem[w_addr];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  always_comb begin
    w_legal   = 1'b1;
    w_is_load = 1'b0;
    w_signed  = 1'b0;
    w_size    = c_SZ_WORD;
    case (w_op)
      6'b000000: begin w_is_load = 1'b1; w_size = c_SZ_WORD; end
      6'b000001: begin w_is_load = 1'b1; w_size = c_SZ_BYTE; end
      6'b000010: begin w_is_load = 1'b1; w_size = c_SZ_HALF; end
      6'b001001: begin w_is_load = 1'b1; w_size = c_SZ_BYTE; w_signed = 1'b1; end
      6'b001010: begin w_is_load = 1'b1; w_size = c_SZ_HALF; w_signed = 1'b1; end
      6'b000100: w_size = c_SZ_WORD;
      6'b000101: w_size = c_SZ_BYTE;
      6'b000110: w_size = c_SZ_HALF;
      default:   w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_aligned = 1'b1;
    if (w_size == c_SZ_HALF)      w_aligned = (w_addr[0] == 1'b0);
    else if (w_size == c_SZ_WORD) w_aligned = (w_addr[1:0] == 2'b00);
  end

  assign w_fault    = !w_legal || !w_aligned;
  assign w_do_store = RESET_n && w_finish && !w_fault && !w_is_load;

  always_comb begin
    w_load_val = {w_b0, w_b1, w_b2, w_b3};
    if (w_size == c_SZ_BYTE)
      w_load_val = {{24{w_signed & w_b0[7]}}, w_b0};
    else if (w_size == c_SZ_HALF)
      w_load_val = {{16{w_signed & w_b0[7]}}, w_b0, w_b1};
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (RAM_enable) w_state_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT:  if (r_count == 4'd1) w_state_next = S_DONE;
      S_DONE:  if (!RAM_enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_addr  <= '0;
      r_op    <= 6'd0;
      r_din   <= 32'd0;
      DataOut <= 32'd0;
      MFC     <= 1'b0;
      MSET    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_count <= c_WAIT_LOAD;
        r_addr  <= Address;
        r_op    <= RAM_OpCode;
        r_din   <= DataIn;
      end else if (r_state == S_WAIT) begin
        r_count <= r_count - 4'd1;
      end
      if (w_finish) begin
        MFC  <= 1'b1;
        MSET <= w_fault;
        if (w_is_load && !w_fault) DataOut <= w_load_val;
      end else if ((r_state == S_DONE) && !RAM_enable) begin
        MFC  <= 1'b0;
        MSET <= 1'b0;
      end
    end
  end

  // Array contents survive reset; only the write strobe is reset-qualified.
  always_ff @(posedge Clk) begin
    if (w_do_store) begin
      case (w_size)
        c_SZ_BYTE: r_mem[w_addr] <= w_din[7:0];
        c_SZ_HALF: begin
          r_mem[w_addr] <= w_din[15:8];
          r_mem[w_a1]   <= w_din[7:0];
        end
        default: begin
          r_mem[w_addr] <= w_din[31:24];
          r_mem[w_a1]   <= w_din[23:16];
          r_mem[w_a2]   <= w_din[15:8];
          r_mem[w_a3]   <= w_din[7:0];
        end
      endcase
    end
  end

endmodule
`default_nettype wire
